// File: rtl/reg_file_pkg.sv
// Shared types and sizing for the register-file read arbiter.
package reg_file_pkg;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [TAG_W-1:0]  reg_tag_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_tag_t  tag;
    } reg_file_rd_req_pkt_t;

    typedef struct packed {
        reg_data_t data;
        reg_tag_t  tag;
    } reg_file_rd_rsp_pkt_t;

    // Index width that stays legal for single-entry arrays.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_multi_arb.sv
// Round-robin selector granting up to K of N requesters per cycle; the k-th
// grant in priority order is bound to output slot k.
module rr_multi_arb
    import reg_file_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 2,
    localparam int NW = idx_w(N),
    localparam int KW = idx_w(K)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N-1:0]          vld,
    output logic [N-1:0]          gnt,
    output logic [N-1:0][KW-1:0]  gnt_port,
    output logic [K-1:0]          port_vld,
    output logic [K-1:0][NW-1:0]  port_ch
);
    logic [NW-1:0] rr_ptr;
    logic [NW-1:0] last;
    logic [NW-1:0] idx;
    logic [KW:0]   cnt;
    logic          any_gnt;

    // Walk channels from rr_ptr, handing out slots until they run out.
    always_comb begin
        gnt      = '0;
        gnt_port = '0;
        port_vld = '0;
        port_ch  = '0;
        cnt      = '0;
        idx      = '0;
        last     = rr_ptr;
        any_gnt  = 1'b0;
        for (int j = 0; j < N; j++) begin
            idx = NW'((int'(rr_ptr) + j) % N);
            if (resetn && vld[idx] && (cnt < (KW+1)'(K))) begin
                gnt[idx]               = 1'b1;
                gnt_port[idx]          = cnt[KW-1:0];
                port_vld[cnt[KW-1:0]]  = 1'b1;
                port_ch[cnt[KW-1:0]]   = idx;
                cnt                    = cnt + (KW+1)'(1);
                last                   = idx;
                any_gnt                = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= (last == NW'(N-1)) ? '0 : last + NW'(1);
        end
    end
endmodule

// File: rtl/reg_file_rd_arb.sv
// Multiplexes NUM_REQ read channels onto NUM_PORTS register-file read ports
// with a one-cycle response pipeline, write forwarding and r0 hardwired to 0.
module reg_file_rd_arb
    import reg_file_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int BYPASS_EN = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [NUM_REQ-1:0]                  req_vld,
    input  reg_file_rd_req_pkt_t [NUM_REQ-1:0]  req_pkt,
    output logic [NUM_REQ-1:0]                  req_rdy,
    output logic [NUM_PORTS-1:0]                rf_rd_en,
    output reg_addr_t [NUM_PORTS-1:0]           rf_rd_addr,
    input  reg_data_t [NUM_PORTS-1:0]           rf_rd_data,
    input  logic                                rf_wr_en,
    input  reg_addr_t                           rf_wr_addr,
    input  reg_data_t                           rf_wr_data,
    output logic [NUM_REQ-1:0]                  rsp_vld,
    output reg_file_rd_rsp_pkt_t [NUM_REQ-1:0]  rsp_pkt
);
    localparam int CHW = idx_w(NUM_REQ);
    localparam int PW  = idx_w(NUM_PORTS);

    logic [NUM_REQ-1:0]                 gnt;
    logic [NUM_REQ-1:0][PW-1:0]         gnt_port;
    logic [NUM_PORTS-1:0]               port_vld;
    logic [NUM_PORTS-1:0][CHW-1:0]      port_ch;

    logic [NUM_REQ-1:0]                 vld_pipe;
    logic [NUM_REQ-1:0]                 zero_q;
    logic [NUM_REQ-1:0]                 byp_q;
    logic [NUM_REQ-1:0]                 byp_hit;
    reg_tag_t [NUM_REQ-1:0]             tag_q;
    logic [NUM_REQ-1:0][PW-1:0]         port_q;
    reg_data_t                          wr_data_q;
    reg_data_t [NUM_REQ-1:0]            rsp_data;

    rr_multi_arb #(
        .N (NUM_REQ),
        .K (NUM_PORTS)
    ) u_arb (
        .clk      (clk),
        .resetn   (resetn),
        .vld      (req_vld),
        .gnt      (gnt),
        .gnt_port (gnt_port),
        .port_vld (port_vld),
        .port_ch  (port_ch)
    );

    // Grant is already gated by resetn inside the selector.
    assign req_rdy = gnt;

    genvar k, i;
    generate
        for (k = 0; k < NUM_PORTS; k++) begin : g_port
            assign rf_rd_en[k]   = port_vld[k];
            assign rf_rd_addr[k] = port_vld[k] ? req_pkt[port_ch[k]].addr : '0;
        end

        for (i = 0; i < NUM_REQ; i++) begin : g_hit
            assign byp_hit[i] = (BYPASS_EN != 0) && rf_wr_en &&
                                (rf_wr_addr == req_pkt[i].addr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= gnt;
        end
    end

    // Payload state is unreset; outputs are zeroed by the valid gate below.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_REQ; c++) begin
            if (gnt[c]) begin
                tag_q[c]  <= req_pkt[c].tag;
                port_q[c] <= gnt_port[c];
                zero_q[c] <= (req_pkt[c].addr == '0);
                byp_q[c]  <= byp_hit[c];
            end
        end
        if (rf_wr_en) begin
            wr_data_q <= rf_wr_data;
        end
    end

    // The array is read-before-write, so a same-cycle write must be forwarded.
    always_comb begin
        rsp_data = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (zero_q[c]) begin
                rsp_data[c] = '0;
            end else if (byp_q[c]) begin
                rsp_data[c] = wr_data_q;
            end else begin
                rsp_data[c] = rf_rd_data[port_q[c]];
            end
        end
    end

    // Gating with resetn discards anything in flight when reset asserts.
    assign rsp_vld = vld_pipe & {NUM_REQ{resetn}};

    always_comb begin
        rsp_pkt = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (rsp_vld[c]) begin
                rsp_pkt[c].data = rsp_data[c];
                rsp_pkt[c].tag  = tag_q[c];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_rd_arb.sv
// Bench for reg_file_rd_arb: directed scenarios plus randomized traffic
// against a queue-based round-robin reference model.
module tb_reg_file_rd_arb;
    import reg_file_pkg::*;

    localparam int NR = 4;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic resetn;
    logic [NR-1:0] req_vld;
    reg_file_rd_req_pkt_t [NR-1:0] req_pkt;
    reg_data_t [NP-1:0] rf_rd_data;
    logic rf_wr_en;
    reg_addr_t rf_wr_addr;
    reg_data_t rf_wr_data;

    logic [NR-1:0] req_rdy, req_rdy_nb, rsp_vld, rsp_vld_nb;
    logic [NP-1:0] rf_rd_en, rf_rd_en_nb;
    reg_addr_t [NP-1:0] rf_rd_addr, rf_rd_addr_nb;
    reg_file_rd_rsp_pkt_t [NR-1:0] rsp_pkt, rsp_pkt_nb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file_rd_arb #(.NUM_REQ(NR), .NUM_PORTS(NP), .BYPASS_EN(1)) u_dut (
        .clk(clk), .resetn(resetn), .req_vld(req_vld), .req_pkt(req_pkt),
        .req_rdy(req_rdy), .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .rsp_vld(rsp_vld), .rsp_pkt(rsp_pkt)
    );

    reg_file_rd_arb #(.NUM_REQ(NR), .NUM_PORTS(NP), .BYPASS_EN(0)) u_dut_nb (
        .clk(clk), .resetn(resetn), .req_vld(req_vld), .req_pkt(req_pkt),
        .req_rdy(req_rdy_nb), .rf_rd_en(rf_rd_en_nb), .rf_rd_addr(rf_rd_addr_nb),
        .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .rsp_vld(rsp_vld_nb), .rsp_pkt(rsp_pkt_nb)
    );

    // Reference: list valid channels in priority order from ptr, keep the first NP.
    function automatic void model_grant(input logic [NR-1:0] v, input int ptr,
                                        output logic [NR-1:0] g, output int ord[NP],
                                        output int ng, output int nptr);
        int q[$];
        int c;
        g = '0;
        ng = 0;
        nptr = ptr;
        for (int p = 0; p < NP; p++) ord[p] = 0;
        for (int j = 0; j < NR; j++) begin
            c = (ptr + j) % NR;
            if (v[c]) q.push_back(c);
        end
        while (q.size() > 0 && ng < NP) begin
            c = q.pop_front();
            g[c] = 1'b1;
            ord[ng] = c;
            ng++;
            nptr = (c + 1) % NR;
        end
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        req_vld = '0;
        rf_wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_vld = 4'hF;
        rf_wr_en = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_pkt[i].addr = reg_addr_t'(i + 1);
            req_pkt[i].tag = reg_tag_t'(i);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== 4'h0 || req_rdy_nb !== 4'h0 || rf_rd_en !== 2'b00 || rf_rd_en_nb !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_grant c=%0d rdy=%b en=%b expected rdy=0000 en=00", c, req_rdy, rf_rd_en);
            end
            n_cmp++;
            if (rsp_vld !== 4'h0 || rsp_vld_nb !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_rsp_vld c=%0d got=%b expected=0000", c, rsp_vld);
            end
            if (c > 0) begin
                n_cmp++;
                if (rsp_pkt !== '0 || rsp_pkt_nb !== '0) begin
                    n_bad++;
                    $display("FAIL reset_rsp_pkt c=%0d got=%h expected=0", c, rsp_pkt);
                end
            end
            @(posedge clk);
            #1;
        end
        resetn = 1'b1;
        req_vld = '0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g, exp_v;
        reg_data_t exp_d;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req_vld = (c < 6) ? 4'hF : 4'h0;
            for (int i = 0; i < NR; i++) begin
                req_pkt[i].addr = reg_addr_t'(i + 1);
                req_pkt[i].tag = reg_tag_t'(c * 4 + i);
            end
            rf_rd_data[0] = 32'hA000_0000 + 32'(c);
            rf_rd_data[1] = 32'hB000_0000 + 32'(c);
            @(negedge clk);
            exp_g = (c >= 6) ? 4'b0000 : ((c % 2 == 0) ? 4'b0011 : 4'b1100);
            n_cmp++;
            if (req_rdy !== exp_g) begin
                n_bad++;
                $display("FAIL rr_grant c=%0d got=%b expected=%b", c, req_rdy, exp_g);
            end
            if (c < 6) begin
                n_cmp++;
                if (rf_rd_addr[0] !== reg_addr_t'((c % 2 == 0) ? 1 : 3) ||
                    rf_rd_addr[1] !== reg_addr_t'((c % 2 == 0) ? 2 : 4)) begin
                    n_bad++;
                    $display("FAIL rr_port_addr c=%0d got=%0d,%0d", c, rf_rd_addr[0], rf_rd_addr[1]);
                end
            end
            if (c > 0) begin
                exp_v = (c % 2 == 1) ? 4'b0011 : 4'b1100;
                n_cmp++;
                if (rsp_vld !== exp_v) begin
                    n_bad++;
                    $display("FAIL rr_rsp_vld c=%0d got=%b expected=%b", c, rsp_vld, exp_v);
                end
                for (int i = 0; i < NR; i++) begin
                    if (exp_v[i]) begin
                        exp_d = (i % 2 == 0) ? 32'hA000_0000 + 32'(c) : 32'hB000_0000 + 32'(c);
                        n_cmp++;
                        if (rsp_pkt[i].tag !== reg_tag_t'((c - 1) * 4 + i) || rsp_pkt[i].data !== exp_d) begin
                            n_bad++;
                            $display("FAIL rr_rsp ch=%0d c=%0d got=%h/%h expected=%h/%h", i, c,
                                     rsp_pkt[i].data, rsp_pkt[i].tag, exp_d, reg_tag_t'((c - 1) * 4 + i));
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            req_vld = 4'b0100;
            req_pkt[2].addr = 5'd5;
            req_pkt[2].tag = 4'h7;
            rf_wr_en = 1'b1;
            rf_wr_addr = (pass == 0) ? 5'd5 : 5'd6;
            rf_wr_data = 32'hDEADBEEF;
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== 4'b0100 || rf_rd_en !== 2'b01 || rf_rd_addr[0] !== 5'd5) begin
                n_bad++;
                $display("FAIL byp_grant pass=%0d rdy=%b en=%b addr=%0d", pass, req_rdy, rf_rd_en, rf_rd_addr[0]);
            end
            @(posedge clk);
            #1;
            req_vld = '0;
            rf_wr_en = 1'b0;
            rf_rd_data[0] = (pass == 0) ? 32'h0 : 32'h1234_5678;
            rf_rd_data[1] = 32'hCAFE_0000;
            @(negedge clk);
            n_cmp++;
            if (rsp_vld !== 4'b0100 || rsp_pkt[2].tag !== 4'h7 ||
                rsp_pkt[2].data !== ((pass == 0) ? 32'hDEADBEEF : 32'h1234_5678)) begin
                n_bad++;
                $display("FAIL byp_on pass=%0d vld=%b data=%h tag=%h", pass, rsp_vld, rsp_pkt[2].data, rsp_pkt[2].tag);
            end
            n_cmp++;
            if (rsp_vld_nb !== 4'b0100 || rsp_pkt_nb[2].data !== ((pass == 0) ? 32'h0 : 32'h1234_5678)) begin
                n_bad++;
                $display("FAIL byp_off pass=%0d vld=%b data=%h", pass, rsp_vld_nb, rsp_pkt_nb[2].data);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_addr_zero();
        do_reset();
        req_vld = 4'b1001;
        req_pkt[0].addr = 5'd0;
        req_pkt[0].tag = 4'h1;
        req_pkt[3].addr = 5'd0;
        req_pkt[3].tag = 4'h2;
        rf_wr_en = 1'b1;
        rf_wr_addr = 5'd0;
        rf_wr_data = 32'h5555_5555;
        @(negedge clk);
        n_cmp++;
        if (req_rdy !== 4'b1001 || rf_rd_en !== 2'b11 || rf_rd_addr[0] !== 5'd0 || rf_rd_addr[1] !== 5'd0) begin
            n_bad++;
            $display("FAIL zero_grant rdy=%b en=%b", req_rdy, rf_rd_en);
        end
        @(posedge clk);
        #1;
        req_vld = '0;
        rf_wr_en = 1'b0;
        rf_rd_data[0] = 32'hFFFF_FFFF;
        rf_rd_data[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++;
        if (rsp_vld !== 4'b1001 || rsp_pkt[0].data !== 32'h0 || rsp_pkt[3].data !== 32'h0 ||
            rsp_pkt[0].tag !== 4'h1 || rsp_pkt[3].tag !== 4'h2) begin
            n_bad++;
            $display("FAIL zero_rsp vld=%b d0=%h d3=%h expected vld=1001 d=0", rsp_vld, rsp_pkt[0].data, rsp_pkt[3].data);
        end
        n_cmp++;
        if (rsp_pkt_nb[0].data !== 32'h0 || rsp_pkt_nb[3].data !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_rsp_nb d0=%h d3=%h expected=0", rsp_pkt_nb[0].data, rsp_pkt_nb[3].data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [NR-1:0] exp_g [3];
        exp_g[0] = 4'b1000;
        exp_g[1] = 4'b0011;
        exp_g[2] = 4'b1100;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_vld = (c == 0) ? 4'b1000 : 4'hF;
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== exp_g[c]) begin
                n_bad++;
                $display("FAIL wrap c=%0d got=%b expected=%b", c, req_rdy, exp_g[c]);
            end
            @(posedge clk);
            #1;
        end
        req_vld = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_vld = 4'hF;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_rdy !== 4'h0 || rsp_vld !== 4'h0 || rsp_vld_nb !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_in rdy=%b rsp_vld=%b expected 0000/0000", req_rdy, rsp_vld);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req_vld = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_vld !== 4'h0 || rsp_vld_nb !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_after rsp_vld=%b expected=0000", rsp_vld);
        end
        @(posedge clk);
        #1;
        req_vld = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (req_rdy !== 4'b0011) begin
            n_bad++;
            $display("FAIL midrst_ptr got=%b expected=0011", req_rdy);
        end
        @(posedge clk);
        #1;
        req_vld = '0;
    endtask

    task automatic test_random(input int cycles);
        logic [NR-1:0] g, pv;
        int ord[NP];
        int ng, nptr, m_ptr, widx;
        int pport[NR];
        reg_addr_t paddr[NR];
        reg_tag_t ptag[NR];
        logic phit[NR];
        reg_data_t pwd, ed, ed_nb;
        reg_addr_t ea;
        do_reset();
        m_ptr = 0;
        pv = '0;
        pwd = '0;
        for (int i = 0; i < NR; i++) begin
            pport[i] = 0; paddr[i] = '0; ptag[i] = '0; phit[i] = 1'b0;
        end
        for (int c = 0; c < cycles; c++) begin
            req_vld = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_pkt[i].addr = reg_addr_t'($urandom_range(0, 7));
                req_pkt[i].tag = reg_tag_t'($urandom);
            end
            widx = $urandom_range(0, NR - 1);
            rf_wr_en = 1'($urandom_range(0, 1));
            rf_wr_addr = ($urandom_range(0, 1) == 1) ? req_pkt[widx].addr : reg_addr_t'($urandom_range(0, 31));
            rf_wr_data = $urandom;
            for (int k = 0; k < NP; k++) rf_rd_data[k] = $urandom;
            model_grant(req_vld, m_ptr, g, ord, ng, nptr);
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== g || req_rdy_nb !== g) begin
                n_bad++;
                $display("FAIL rnd_grant c=%0d vld=%b got=%b expected=%b", c, req_vld, req_rdy, g);
            end
            for (int k = 0; k < NP; k++) begin
                ea = (k < ng) ? req_pkt[ord[k]].addr : '0;
                n_cmp++;
                if (rf_rd_en[k] !== (k < ng) || rf_rd_addr[k] !== ea || rf_rd_addr_nb[k] !== ea) begin
                    n_bad++;
                    $display("FAIL rnd_port c=%0d k=%0d en=%b addr=%0d expected en=%0d addr=%0d",
                             c, k, rf_rd_en[k], rf_rd_addr[k], (k < ng), ea);
                end
            end
            n_cmp++;
            if (rsp_vld !== pv || rsp_vld_nb !== pv) begin
                n_bad++;
                $display("FAIL rnd_rsp_vld c=%0d got=%b expected=%b", c, rsp_vld, pv);
            end
            for (int i = 0; i < NR; i++) begin
                if (pv[i]) begin
                    ed_nb = (paddr[i] == '0) ? '0 : rf_rd_data[pport[i]];
                    ed = (paddr[i] == '0) ? '0 : (phit[i] ? pwd : ed_nb);
                    n_cmp++;
                    if (rsp_pkt[i].data !== ed || rsp_pkt[i].tag !== ptag[i] ||
                        rsp_pkt_nb[i].data !== ed_nb || rsp_pkt_nb[i].tag !== ptag[i]) begin
                        n_bad++;
                        $display("FAIL rnd_rsp c=%0d ch=%0d got=%h/%h nb=%h expected=%h/%h nb=%h", c, i,
                                 rsp_pkt[i].data, rsp_pkt[i].tag, rsp_pkt_nb[i].data, ed, ptag[i], ed_nb);
                    end
                end
            end
            pv = g;
            for (int k = 0; k < ng; k++) pport[ord[k]] = k;
            for (int i = 0; i < NR; i++) begin
                paddr[i] = req_pkt[i].addr;
                ptag[i] = req_pkt[i].tag;
                phit[i] = rf_wr_en && (rf_wr_addr == req_pkt[i].addr);
            end
            pwd = rf_wr_data;
            m_ptr = nptr;
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        rf_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_vld = '0;
        req_pkt = '0;
        rf_rd_data = '0;
        rf_wr_en = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        #1;
        test_reset();
        test_round_robin();
        test_bypass();
        test_addr_zero();
        test_wrap();
        test_reset_mid();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file_rd_arb.md
REG_FILE_RD_ARB -- requirements
Module: reg_file_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester read-request channels (2..8).
REQ-002 Parameter NUM_PORTS, default 2, number of physical register-file read ports (1..NUM_REQ).
REQ-003 Parameter BYPASS_EN, default 1, enables write-to-read forwarding.
REQ-004 Ports, one per line (name  direction  width  meaning):
  clk  input  1  sole clock; one clock, all logic on posedge clk
  resetn  input  1  reset, synchronous, active-low
  req_vld  input  [NUM_REQ]  per-channel request valid
  req_pkt  input  reg_file_rd_req_pkt_t[NUM_REQ]  per-channel request (addr, tag)
  req_rdy  output  [NUM_REQ]  per-channel grant; a transfer occurs when vld & rdy
  rf_rd_en  output  [NUM_PORTS]  physical read-port enable
  rf_rd_addr  output  reg_addr_t[NUM_PORTS]  physical read-port address
  rf_rd_data  input  reg_data_t[NUM_PORTS]  read data, valid one cycle after rf_rd_en
  rf_wr_en  input  1  register-file write enable (snooped)
  rf_wr_addr  input  reg_addr_t  write address (snooped)
  rf_wr_data  input  reg_data_t  write data (snooped)
  rsp_vld  output  [NUM_REQ]  per-channel response valid; no backpressure
  rsp_pkt  output  reg_file_rd_rsp_pkt_t[NUM_REQ]  per-channel response (data, tag)

Function
REQ-005 Each cycle the block SHALL grant at most NUM_PORTS requests, chosen round-robin starting at priority pointer rr_ptr.
REQ-006 req_rdy[i] SHALL depend combinationally on req_vld and rr_ptr only, never on req_pkt.
REQ-007 The k-th granted channel in round-robin order SHALL be mapped to physical port k; rf_rd_en[k]=1 and rf_rd_addr[k]=granted addr; unused ports drive rf_rd_en=0, rf_rd_addr=0.
REQ-008 When at least one grant occurs, rr_ptr SHALL advance to (last granted index + 1) mod NUM_REQ; with no grants rr_ptr SHALL hold.
REQ-009 A request granted in cycle N SHALL produce rsp_vld[i]=1 in cycle N+1 only, with rsp_pkt.tag equal to the request tag.
REQ-010 rsp_pkt.data SHALL equal rf_rd_data[k] of the port used, except as overridden by REQ-011/012.
REQ-011 With BYPASS_EN=1, if rf_wr_en=1 in cycle N and rf_wr_addr equals a granted addr, the response SHALL return rf_wr_data captured in cycle N; the register file is read-before-write.
REQ-012 Reads of addr 0 SHALL return data 0 regardless of rf_rd_data or bypass.
REQ-013 Multiple channels reading the same addr in one cycle SHALL each receive independent, identical responses.
REQ-014 When NUM_PORTS >= number of valid requests, all valid requests SHALL be granted in the same cycle.
REQ-015 Any channel holding req_vld=1 continuously SHALL be granted within ceil(NUM_REQ/NUM_PORTS) cycles.
REQ-016 rr_ptr wrap from NUM_REQ-1 to 0 SHALL be seamless, with no skipped or doubled channel.

Reset
REQ-017 While resetn=0 at a posedge: rr_ptr<=0, all pipeline-valid state <=0; next cycle rsp_vld=0, rsp_pkt=0.
REQ-018 During reset req_rdy=0 and rf_rd_en=0 combinationally.
REQ-019 A request granted in the cycle resetn falls SHALL NOT produce a response; in-flight responses are discarded.

Structure
REQ-020 reg_addr_t, reg_data_t, reg_file_rd_req_pkt_t {addr, tag} and new reg_file_rd_rsp_pkt_t {data, tag} SHALL live in reg_file_pkg; NUM_REGS=32, DATA_W=32, TAG_W=4 are package constants.
REQ-021 The round-robin multi-grant selector SHALL be a sub-module rr_multi_arb (params N, K); the response pipeline register and bypass mux stay in reg_file_rd_arb.

Verification
REQ-022 Reset: hold resetn=0 3 cycles with req_vld=4'hF -> req_rdy=0, rf_rd_en=0, rsp_vld=0 throughout.
REQ-023 All 4 channels valid continuously, NUM_PORTS=2 -> grants {0,1},{2,3},{0,1}...; each response one cycle later with correct tag.
REQ-024 Channel 2 reads addr 5 while rf_wr_en=1, addr 5, data 32'hDEADBEEF; rf_rd_data=32'h0 -> rsp_pkt[2].data=32'hDEADBEEF; same with BYPASS_EN=0 -> 32'h0.
REQ-025 Channels 0 and 3 both read addr 0, rf_rd_data=32'hFFFFFFFF -> both rsp data 0, both granted same cycle.
REQ-026 Only channel 3 valid, then channels 0-3 valid -> rr_ptr wraps to 0, next grants {0,1}.
REQ-027 Grant in cycle N, resetn=0 in cycle N -> rsp_vld stays 0 in N+1.
